// File: rtl/mips32_core.sv
// Single-cycle MIPS32 core: fetch, decode, execute and retire one instruction per clk.
// Register and data-memory reads are combinational, and writes land on the rising edge.

module mips_imem #(
  parameter int WORDS = 32,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          load_vld,
  input  logic [AW-1:0] load_idx,
  input  logic [31:0]   load_dat,
  input  logic [AW-1:0] idx,
  output logic [31:0]   ins
);
  logic [31:0] instructions [0:WORDS-1];

  // Loader port, tied off at the core. The array is normally filled by backdoor.
  always_ff @(posedge clk) begin
    if (load_vld) instructions[load_idx] <= load_dat;
  end

  assign ins = instructions[idx];
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) registers[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module mips_dmem #(
  parameter int WORDS = 256,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  logic [31:0] _data_memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) _data_memory[idx] <= wd;
  end

  assign rd = _data_memory[idx];
endmodule

module mips32_core #(
  parameter int IMEM_WORDS = 32,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] PC_in, ins, next_pc, pc_plus4, br_target, j_target;
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm, sum_i, reg_wd, mem_rd;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, reg_wa;
  logic [15:0] imm;
  logic [25:0] target;
  logic        reg_we, mem_we;

  assign opcode = ins[31:26];
  assign rs     = ins[25:21];
  assign rt     = ins[20:16];
  assign rd     = ins[15:11];
  assign shamt  = ins[10:6];
  assign funct  = ins[5:0];
  assign imm    = ins[15:0];
  assign target = ins[25:0];

  assign sext_imm  = {{16{imm[15]}}, imm};
  assign zext_imm  = {16'h0, imm};
  assign sum_i     = rs_val + sext_imm;
  assign pc_plus4  = PC_in + 32'd4;
  assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], target, 2'b00};

  mips_imem #(.WORDS(IMEM_WORDS)) ins_mem (
    .clk      (clk),
    .load_vld (1'b0),
    .load_idx ('0),
    .load_dat (32'd0),
    .idx      (PC_in[IAW+1:2]),
    .ins      (ins)
  );

  // Writes are suppressed on a reset edge so that the in-flight instruction has no effect.
  mips_regfile my_mips_registers (
    .clk (clk),
    .we  (reg_we && !reset),
    .wa  (reg_wa),
    .wd  (reg_wd),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  mips_dmem #(.WORDS(DMEM_WORDS)) m_memory (
    .clk (clk),
    .we  (mem_we && !reset),
    .idx (sum_i[DAW+1:2]),
    .wd  (rt_val),
    .rd  (mem_rd)
  );

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rd;
    reg_wd  = 32'd0;
    mem_we  = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h20: reg_wd = rs_val + rt_val;
          6'h22: reg_wd = rs_val - rt_val;
          6'h24: reg_wd = rs_val & rt_val;
          6'h25: reg_wd = rs_val | rt_val;
          6'h27: reg_wd = ~(rs_val | rt_val);
          6'h2A: reg_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: reg_wd = {31'd0, rs_val < rt_val};
          6'h00: reg_wd = rt_val << shamt;
          6'h02: reg_wd = rt_val >> shamt;
          6'h08: begin
            reg_we  = 1'b0;
            next_pc = rs_val;
          end
          default: reg_we = 1'b0;
        endcase
      end
      6'h08: begin reg_we = 1'b1; reg_wa = rt; reg_wd = sum_i; end
      6'h0A: begin reg_we = 1'b1; reg_wa = rt; reg_wd = {31'd0, $signed(rs_val) < $signed(sext_imm)}; end
      6'h0C: begin reg_we = 1'b1; reg_wa = rt; reg_wd = rs_val & zext_imm; end
      6'h0D: begin reg_we = 1'b1; reg_wa = rt; reg_wd = rs_val | zext_imm; end
      6'h0F: begin reg_we = 1'b1; reg_wa = rt; reg_wd = {imm, 16'h0}; end
      6'h23: begin reg_we = 1'b1; reg_wa = rt; reg_wd = mem_rd; end
      6'h2B: mem_we = 1'b1;
      6'h04: if (rs_val == rt_val) next_pc = br_target;
      6'h05: if (rs_val != rt_val) next_pc = br_target;
      6'h02: next_pc = j_target;
      6'h03: begin
        next_pc = j_target;
        reg_we  = 1'b1;
        reg_wa  = 5'd31;
        reg_wd  = pc_plus4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) PC_in <= 32'd0;
    else       PC_in <= next_pc;
  end

  assign pc_out    = PC_in;
  assign instr_out = ins;
endmodule

// File: tb/tb_mips32_core.sv
// Directed-program bench for mips32_core: programs are loaded by backdoor, and results are read back from the PC, registers and memory.
module tb_mips32_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_out, instr_out;
  logic [31:0] prog [0:31];
  int n_cmp = 0;
  int n_bad = 0;

  mips32_core dut (.clk(clk), .reset(reset), .pc_out(pc_out), .instr_out(instr_out));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, copy prog[] into instruction memory, and release after two reset edges.
  task automatic load_and_reset();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) dut.ins_mem.instructions[i] <= prog[i];
    step();
    step();
    check("reset_pc", pc_out, 32'h0);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rf(input int r);
    return dut.my_mips_registers.registers[r];
  endfunction

  initial begin
    // ALU / memory program
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    prog[0]  = i_op(8'h08, 0, 1, 5);
    prog[1]  = i_op(8'h08, 0, 2, 'hFFFD);
    prog[2]  = r_op(1, 2, 3, 0, 'h20);
    prog[3]  = r_op(1, 2, 4, 0, 'h22);
    prog[4]  = r_op(2, 1, 5, 0, 'h2A);
    prog[5]  = r_op(0, 1, 6, 4, 'h00);
    prog[6]  = i_op(8'h0F, 0, 7, 'h1234);
    prog[7]  = i_op(8'h08, 0, 1, 8);
    prog[8]  = i_op(8'h2B, 1, 2, 4);
    prog[9]  = i_op(8'h23, 1, 8, 4);
    prog[10] = i_op(8'h08, 0, 0, 7);
    prog[11] = i_op(8'h08, 0, 12, 'h55);
    prog[12] = i_op(8'h2B, 1, 1, 'hFFF8);
    prog[13] = r_op(1, 2, 10, 0, 'h2B);
    prog[14] = r_op(0, 2, 11, 28, 'h02);
    prog[15] = r_op(1, 0, 9, 0, 'h27);
    load_and_reset();
    check("fetch_pc0", pc_out, 32'h0);
    check("fetch_ins0", instr_out, prog[0]);
    step();
    check("fetch_pc1", pc_out, 32'h4);
    check("fetch_ins1", instr_out, prog[1]);
    step();
    check("fetch_pc2", pc_out, 32'h8);
    check("fetch_ins2", instr_out, prog[2]);
    repeat (14) step();
    check("alu_pc_end", pc_out, 32'h40);
    check("add", rf(3), 32'd2);
    check("sub", rf(4), 32'd8);
    check("slt", rf(5), 32'd1);
    check("sll", rf(6), 32'd80);
    check("lui", rf(7), 32'h1234_0000);
    check("sw_mem3", dut.m_memory._data_memory[3], 32'hFFFF_FFFD);
    check("lw", rf(8), 32'hFFFF_FFFD);
    check("zero_reg", rf(12), 32'h55);
    check("sw_neg_mem0", dut.m_memory._data_memory[0], 32'h8);
    check("sltu", rf(10), 32'd1);
    check("srl", rf(11), 32'hF);
    check("nor", rf(9), 32'hFFFF_FFF7);

    // Branch program
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    prog[0] = i_op(8'h08, 0, 1, 1);
    prog[1] = i_op(8'h08, 0, 2, 1);
    prog[4] = i_op(8'h04, 1, 2, 2);
    prog[5] = i_op(8'h08, 0, 13, 'hBAD);
    prog[6] = i_op(8'h08, 0, 13, 'hBAD);
    prog[7] = i_op(8'h05, 1, 2, 5);
    prog[8] = i_op(8'h04, 0, 0, 'hFFFF);
    load_and_reset();
    repeat (4) step();
    check("br_at_10", pc_out, 32'h10);
    check("br_ins", instr_out, prog[4]);
    step();
    check("beq_taken", pc_out, 32'h1C);
    step();
    check("bne_not_taken", pc_out, 32'h20);
    step();
    check("beq_self_1", pc_out, 32'h20);
    step();
    check("beq_self_2", pc_out, 32'h20);

    // Jump / reset-mid-program
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    prog[0]  = i_op(8'h08, 0, 1, 'h77);
    prog[2]  = j_op(8'h03, 'h10);
    prog[16] = r_op(31, 0, 0, 0, 'h08);
    prog[3]  = j_op(8'h02, 'h08);
    prog[8]  = i_op(8'h2B, 0, 1, 0);
    load_and_reset();
    step();
    step();
    check("jal_pc_before", pc_out, 32'h8);
    step();
    check("jal_pc", pc_out, 32'h40);
    check("jal_ra", rf(31), 32'h0C);
    step();
    check("jr_pc", pc_out, 32'h0C);
    step();
    check("j_pc", pc_out, 32'h20);
    check("sw_ins", instr_out, prog[8]);
    reset = 1'b1;
    step();
    check("rst_mid_pc", pc_out, 32'h0);
    check("rst_mid_mem0", dut.m_memory._data_memory[0], 32'h8);
    check("rst_mid_r1", rf(1), 32'h77);
    check("rst_mid_r31", rf(31), 32'h0C);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
